// File: rtl/sqrt_state_seq.sv
`timescale 1ns/1ps
// Purpose: control sequencer for a digit-recurrence square-root unit; emits a registered 4-bit state code.
// Latency: DONE is reached 3+7*ITER cycles after start is sampled in IDLE; each root digit takes 7 cycles.
// Backpressure: four-phase handshake, DONE holds while start stays high. Optional abort via SQRT_SEQ_ABORT_EN.
module sqrt_state_seq #(
    parameter int ITER = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       neg,
`ifdef SQRT_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic [3:0] Q,
    output logic       busy,
    output logic [3:0] iter_cnt
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0000,
        LOAD    = 4'b0001,
        INIT    = 4'b0010,
        SHIFT   = 4'b0011,
        SUB     = 4'b0100,
        TEST    = 4'b0101,
        RESTORE = 4'b0110,
        SETBIT  = 4'b0111,
        UPD     = 4'b1000,
        DEC     = 4'b1001,
        CHK     = 4'b1010,
        FIN     = 4'b1011,
        DONE    = 4'b1101
    } state_t;

    // Held as plain bits so the unused codes 1100/1110/1111 are representable and recoverable.
    logic [3:0] state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // State and iteration counter registers; reset forces IDLE with a cleared count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-count decode; abort (when built in) overrides every other condition.
    always_comb begin
        state_d = state_t'(state_q);
        cnt_d   = cnt_q;
        case (state_t'(state_q))
            IDLE: begin
                cnt_d = 4'd0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD:    state_d = INIT;
            INIT: begin
                state_d = SHIFT;
                cnt_d   = 4'(ITER);
            end
            SHIFT:   state_d = SUB;
            SUB:     state_d = TEST;
            TEST:    state_d = neg ? RESTORE : SETBIT;
            RESTORE: state_d = UPD;
            SETBIT:  state_d = UPD;
            UPD:     state_d = DEC;
            DEC: begin
                state_d = CHK;
                cnt_d   = cnt_q - 4'd1;
            end
            CHK:     state_d = (cnt_q == 4'd0) ? FIN : SHIFT;
            FIN:     state_d = DONE;
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
`ifdef SQRT_SEQ_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end
`endif
    end

    assign Q        = state_q;
    assign iter_cnt = cnt_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_sqrt_state_seq.sv
`timescale 1ns/1ps
module tb_sqrt_state_seq;

    localparam int ITER = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       neg = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] Q;
    logic       busy;
    logic [3:0] iter_cnt;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: operation described by the number of edges since start was accepted.
    int m_state = 0;   // 0 idle, 1 running, 2 done
    int m_t     = 0;
    bit m_rest  = 1'b0;

    sqrt_state_seq #(.ITER(ITER)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .neg      (neg),
`ifdef SQRT_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .Q        (Q),
        .busy     (busy),
        .iter_cnt (iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_q();
        int p;
        if (m_state == 0) return 0;
        if (m_state == 2) return 13;
        if (m_t == 0) return 1;
        if (m_t == 1) return 2;
        if (m_t == 2 + 7 * ITER) return 11;
        p = (m_t - 2) % 7;
        case (p)
            0: return 3;
            1: return 4;
            2: return 5;
            3: return m_rest ? 6 : 7;
            4: return 8;
            5: return 9;
            default: return 10;
        endcase
    endfunction

    function automatic int exp_cnt();
        int i;
        int p;
        if (m_state != 1) return 0;
        if (m_t < 2 || m_t >= 2 + 7 * ITER) return 0;
        i = (m_t - 2) / 7;
        p = (m_t - 2) % 7;
        return (p <= 5) ? ITER - i : ITER - i - 1;
    endfunction

    function automatic void model_next(input bit s, input bit n, input bit a);
`ifdef SQRT_SEQ_ABORT_EN
        if (a && m_state != 0) begin
            m_state = 0;
            return;
        end
`endif
        case (m_state)
            0: if (s) begin
                m_state = 1;
                m_t     = 0;
            end
            1: begin
                if (m_t >= 2 && m_t < 2 + 7 * ITER && (m_t - 2) % 7 == 2) m_rest = n;
                m_t++;
                if (m_t == 3 + 7 * ITER) m_state = 2;
            end
            default: if (!s) m_state = 0;
        endcase
    endfunction

    // One clock: drive on the falling edge, advance the model, compare just after the rising edge.
    task automatic step(input bit s, input bit n, input bit a);
        @(negedge clk);
        start = s;
        neg   = n;
        abort = a;
        model_next(s, n, a);
        @(posedge clk);
        #1;
        chk("q", Q, exp_q());
        chk("iter_cnt", iter_cnt, exp_cnt());
        chk("busy", busy, (m_state == 1) ? 1 : 0);
    endtask

    task automatic run_op(input bit n, input string tag);
        int lat;
        lat = -1;
        step(1'b1, n, 1'b0);
        for (int c = 1; c <= 200; c++) begin
            step(1'b0, n, 1'b0);
            if (Q == 4'b1101) begin
                lat = c;
                break;
            end
        end
        chk(tag, lat, 3 + 7 * ITER);
        step(1'b0, n, 1'b0);
    endtask

    initial begin
        bit s;
        // Reset state, asserted without any clock edge having occurred.
        #2;
        chk("rst_q", Q, 0);
        chk("rst_iter", iter_cnt, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Full operation, no restores, then all restores.
        run_op(1'b0, "latency_neg0");
        run_op(1'b1, "latency_neg1");

        // Start held through DONE: no relaunch, DONE holds, then drops to IDLE.
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3 + 7 * ITER + 10; c++) step(1'b1, 1'b0, 1'b0);
        chk("done_hold", Q, 13);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the SUB state of the third iteration.
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 17; c++) step(1'b0, 1'b0, 1'b0);
        chk("pre_rst_q", Q, 4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", Q, 0);
        chk("async_rst_iter", iter_cnt, 0);
        chk("async_rst_busy", busy, 0);
        m_state = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0);

        // Illegal state code recovers to IDLE on the next edge.
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        force dut.state_q = 4'b1110;
        #1;
        release dut.state_q;
        chk("forced_q", Q, 14);
        @(posedge clk);
        #1;
        chk("illegal_q", Q, 0);
        chk("illegal_iter", iter_cnt, 0);
        m_state = 0;
        step(1'b0, 1'b0, 1'b0);

`ifdef SQRT_SEQ_ABORT_EN
        // Abort in CHK with five iterations left and start still high.
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 22; c++) step(1'b1, 1'b0, 1'b0);
        chk("pre_abort_q", Q, 10);
        chk("pre_abort_iter", iter_cnt, 5);
        step(1'b1, 1'b0, 1'b1);
        chk("abort_q", Q, 0);
        chk("abort_iter", iter_cnt, 0);
        step(1'b0, 1'b0, 1'b0);
`endif

        // Randomised traffic: sticky start with occasional toggles, random neg and rare abort.
        s = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            bit a;
            if ($urandom_range(0, 7) == 0) s = ~s;
            a = 1'b0;
`ifdef SQRT_SEQ_ABORT_EN
            a = ($urandom_range(0, 99) == 0);
`endif
            step(s, 1'($urandom_range(0, 1)), a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
